// File: rtl/tt_um_jleugeri_ttt_scheduler_if.sv
// Token stream and connection-table lookup bundle for the TTT scheduler.
// master = scheduler side, slave = demux / connection-table side.
interface tt_um_jleugeri_ttt_scheduler_if #(
  parameter int IDX_BITS = 4
);
  logic [IDX_BITS-1:0] src_idx_out;
  logic [IDX_BITS-1:0] range_lo_in;
  logic [IDX_BITS-1:0] range_hi_in;
  logic                tgt_valid_out;
  logic                tgt_ready_in;
  logic [IDX_BITS-1:0] tgt_idx_out;
  logic                tgt_sign_out;

  modport master (
    output src_idx_out, tgt_valid_out, tgt_idx_out, tgt_sign_out,
    input  range_lo_in, range_hi_in, tgt_ready_in
  );

  modport slave (
    input  src_idx_out, tgt_valid_out, tgt_idx_out, tgt_sign_out,
    output range_lo_in, range_hi_in, tgt_ready_in
  );
endinterface

// File: rtl/tt_um_jleugeri_ttt_scheduler.sv
// Time-to-token sweep sequencer: snapshots start/stop flags, scans sources, fans tokens out.
// Optional macro TTT_SCHED_SELF_SKIP_EN: skip targets equal to the current source index.
module tt_um_jleugeri_ttt_scheduler #(
  parameter int NUM_PROCESSORS = 10,
  parameter int IDX_BITS       = $clog2(NUM_PROCESSORS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        go_in,
  output logic                        hot_out,
  output logic                        done_out,
  input  logic [2*NUM_PROCESSORS-1:0] tstartstop_in,
  tt_um_jleugeri_ttt_scheduler_if.master tgt
);

  localparam logic [IDX_BITS-1:0] LAST = IDX_BITS'(NUM_PROCESSORS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FANOUT,
    DONE
  } state_t;

  state_t                      state, state_d;
  logic [2*NUM_PROCESSORS-1:0] snap, snap_d;
  logic [IDX_BITS-1:0]         idx, idx_d;
  logic [IDX_BITS-1:0]         cnt, cnt_d;
  logic [IDX_BITS-1:0]         hi, hi_d;
  logic                        sign, sign_d;

  logic [1:0]          pair;
  logic                net_event;
  logic [IDX_BITS-1:0] hi_clamp;
  logic [IDX_BITS-1:0] first_tgt;
  logic [IDX_BITS-1:0] next_cnt;
  logic                empty;
  logic                last_tgt;
  logic                handshake;

  // Range decode for the source under scan, and the counter step for FANOUT.
  always_comb begin
    pair      = snap[{idx, 1'b0} +: 2];
    net_event = pair[0] ^ pair[1];
    hi_clamp  = (tgt.range_hi_in > LAST) ? LAST : tgt.range_hi_in;
    first_tgt = tgt.range_lo_in;
    empty     = (tgt.range_lo_in > LAST) || (tgt.range_lo_in > hi_clamp);
    next_cnt  = cnt + 1'b1;
    last_tgt  = (cnt == hi);
`ifdef TTT_SCHED_SELF_SKIP_EN
    if (!empty && (first_tgt == idx)) begin
      if (first_tgt == hi_clamp) empty = 1'b1;
      else                       first_tgt = first_tgt + 1'b1;
    end
    // A self-target at hi ends the range one step early instead of being emitted.
    if (!last_tgt && (next_cnt == idx)) begin
      if (idx == hi) last_tgt = 1'b1;
      else           next_cnt = cnt + 2'd2;
    end
`endif
  end

  assign handshake = tgt.tgt_valid_out && tgt.tgt_ready_in;

  always_comb begin
    state_d = state;
    snap_d  = snap;
    idx_d   = idx;
    cnt_d   = cnt;
    hi_d    = hi;
    sign_d  = sign;
    unique case (state)
      IDLE: begin
        if (go_in) begin
          snap_d  = tstartstop_in;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (net_event && !empty) begin
          cnt_d   = first_tgt;
          hi_d    = hi_clamp;
          sign_d  = pair[1];
          state_d = FANOUT;
        end else if (idx == LAST) begin
          state_d = DONE;
        end else begin
          idx_d = idx + 1'b1;
        end
      end
      FANOUT: begin
        if (handshake) begin
          if (last_tgt) begin
            if (idx == LAST) begin
              state_d = DONE;
            end else begin
              idx_d   = idx + 1'b1;
              state_d = SCAN;
            end
          end else begin
            cnt_d = next_cnt;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      snap  <= '0;
      idx   <= '0;
      cnt   <= '0;
      hi    <= '0;
      sign  <= 1'b0;
    end else begin
      state <= state_d;
      snap  <= snap_d;
      idx   <= idx_d;
      cnt   <= cnt_d;
      hi    <= hi_d;
      sign  <= sign_d;
    end
  end

  assign hot_out           = (state == SCAN) || (state == FANOUT);
  assign done_out          = (state == DONE);
  assign tgt.tgt_valid_out = (state == FANOUT);
  assign tgt.tgt_idx_out   = cnt;
  assign tgt.tgt_sign_out  = sign;
  assign tgt.src_idx_out   = idx;

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_scheduler.sv
// Scoreboard bench for the TTT scheduler: directed sweeps, monitor pops expected tokens.
module tb_tt_um_jleugeri_ttt_scheduler;

  localparam int N  = 10;
  localparam int IB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          go_in = 1'b0;
  logic          hot_out;
  logic          done_out;
  logic [2*N-1:0] tstartstop_in = '0;

  tt_um_jleugeri_ttt_scheduler_if #(.IDX_BITS(IB)) bus ();

  tt_um_jleugeri_ttt_scheduler #(.NUM_PROCESSORS(N), .IDX_BITS(IB)) dut (
    .clk           (clk),
    .reset         (reset),
    .go_in         (go_in),
    .hot_out       (hot_out),
    .done_out      (done_out),
    .tstartstop_in (tstartstop_in),
    .tgt           (bus)
  );

  always #5 clk = ~clk;

  logic [IB-1:0] lo_tab [16];
  logic [IB-1:0] hi_tab [16];
  always_comb begin
    bus.range_lo_in = lo_tab[bus.src_idx_out];
    bus.range_hi_in = hi_tab[bus.src_idx_out];
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;
  int done_count = 0;
  logic [IB:0] sb_q [$];

  logic ready_level = 1'b1;
  logic ready_toggle = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_tok(input int idx, input int sgn);
    sb_q.push_back({1'(sgn), IB'(idx)});
  endtask

  initial begin
    bus.tgt_ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.tgt_ready_in = ready_toggle ? ((cyc % 3) == 0) : ready_level;
    end
  end

  // Monitor: pops one expected token per handshake, checks hold-until-handshake.
  logic          prev_stall = 1'b0;
  logic [IB-1:0] prev_idx;
  logic          prev_sign;
  initial begin
    logic [IB:0] e;
    forever begin
      @(negedge clk);
      if (done_out === 1'b1) done_count++;
      if (prev_stall) begin
        check("hold_valid", int'(bus.tgt_valid_out), 1);
        check("hold_idx", int'(bus.tgt_idx_out), int'(prev_idx));
        check("hold_sign", int'(bus.tgt_sign_out), int'(prev_sign));
      end
      if (bus.tgt_valid_out === 1'b1 && bus.tgt_ready_in === 1'b1 && reset === 1'b0) begin
        if (sb_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_token: got idx %0d sign %0d expected none",
                   bus.tgt_idx_out, bus.tgt_sign_out);
        end else begin
          e = sb_q.pop_front();
          check("tok_idx", int'(bus.tgt_idx_out), int'(e[IB-1:0]));
          check("tok_sign", int'(bus.tgt_sign_out), int'(e[IB]));
        end
      end
      prev_stall = (bus.tgt_valid_out === 1'b1) && (bus.tgt_ready_in !== 1'b1) && (reset === 1'b0);
      prev_idx   = bus.tgt_idx_out;
      prev_sign  = bus.tgt_sign_out;
    end
  end

  int unsigned k;

  task automatic set_tables();
    for (int i = 0; i < 16; i++) begin
      lo_tab[i] = 4'd0;
      hi_tab[i] = 4'd9;
    end
  endtask

  task automatic start_sweep(input logic [2*N-1:0] ev);
    @(posedge clk);
    #1;
    tstartstop_in = ev;
    go_in = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    go_in = 1'b0;
    tstartstop_in = '0;
  endtask

  // done_at is reported in the numbering where the first SCAN cycle is k+1.
  task automatic wait_done(input string name, input int exp_done_at, input int exp_hot);
    int hot_cnt;
    bit seen;
    hot_cnt = 0;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done_out === 1'b1) begin
        seen = 1;
        break;
      end
      if (hot_out === 1'b1) hot_cnt++;
    end
    check({name, "_done_seen"}, int'(seen), 1);
    if (seen) begin
      check({name, "_hot_low_at_done"}, int'(hot_out), 0);
      if (exp_done_at >= 0) check({name, "_done_at"}, int'(cyc - k + 1), exp_done_at);
      if (exp_hot >= 0) check({name, "_hot_cycles"}, hot_cnt, exp_hot);
    end
    repeat (2) @(posedge clk);
    check({name, "_sb_empty"}, sb_q.size(), 0);
  endtask

  initial begin
    bit got_valid;
    int dc0;
    set_tables();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hot", int'(hot_out), 0);
    check("rst_done", int'(done_out), 0);
    check("rst_valid", int'(bus.tgt_valid_out), 0);
    check("rst_idx", int'(bus.tgt_idx_out), 0);
    check("rst_sign", int'(bus.tgt_sign_out), 0);
    check("rst_src", int'(bus.src_idx_out), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // 1: no events
    start_sweep('0);
    wait_done("empty", 11, 10);

    // 2: proc 3 start, range 5..7
    set_tables();
    lo_tab[3] = 4'd5; hi_tab[3] = 4'd7;
    push_tok(5, 0); push_tok(6, 0); push_tok(7, 0);
    start_sweep(20'h00040);
    wait_done("p3", 14, 13);

    // 3: proc 2 stop, range 1..2, throttled consumer
    set_tables();
    lo_tab[2] = 4'd1; hi_tab[2] = 4'd2;
    push_tok(1, 1); push_tok(2, 1);
    ready_toggle = 1'b1;
    start_sweep(20'h00020);
    wait_done("p2", -1, -1);
    ready_toggle = 1'b0;

    // 4: proc 4 both (net zero), proc 9 start with range 8..12 clamped to 8..9
    set_tables();
    lo_tab[9] = 4'd8; hi_tab[9] = 4'd12;
    push_tok(8, 0); push_tok(9, 0);
    start_sweep(20'h40300);
    wait_done("clamp", 13, 12);

    // 5: proc 6 start, range 5..7 (self-target)
    set_tables();
    lo_tab[6] = 4'd5; hi_tab[6] = 4'd7;
    push_tok(5, 0);
`ifndef TTT_SCHED_SELF_SKIP_EN
    push_tok(6, 0);
`endif
    push_tok(7, 0);
    start_sweep(20'h01000);
`ifdef TTT_SCHED_SELF_SKIP_EN
    wait_done("self", 13, 12);
`else
    wait_done("self", 14, 13);
`endif

    // 6: reset during a stalled FANOUT, then a sweep with a stray mid-sweep go
    set_tables();
    lo_tab[3] = 4'd5; hi_tab[3] = 4'd7;
    ready_level = 1'b0;
    start_sweep(20'h00040);
    got_valid = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.tgt_valid_out === 1'b1) begin
        got_valid = 1;
        break;
      end
    end
    check("rst_mid_reach_fanout", int'(got_valid), 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_valid", int'(bus.tgt_valid_out), 0);
    check("rst_mid_hot", int'(hot_out), 0);
    check("rst_mid_src", int'(bus.src_idx_out), 0);
    sb_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    ready_level = 1'b1;
    push_tok(5, 0); push_tok(6, 0); push_tok(7, 0);
    dc0 = done_count;
    start_sweep(20'h00040);
    repeat (3) @(posedge clk);
    #1 go_in = 1'b1;
    @(posedge clk);
    #1 go_in = 1'b0;
    wait_done("rego", 14, -1);
    repeat (25) @(posedge clk);
    @(negedge clk);
    check("rego_done_pulses", done_count - dc0, 1);
    check("rego_idle_hot", int'(hot_out), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
